// File: rtl/clock_pkg.sv
// Shared types, field limits and BCD/12-hour helpers for the time-of-day counter.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    function automatic logic [7:0] to_bcd2(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 6'd10);
        o = 4'(v - 6'(t) * 6'd10);
        return {t, o};
    endfunction

    function automatic logic [4:0] hr_to_12(input logic [4:0] h);
        if (h == 5'd0) return 5'd12;
        if (h > 5'd12) return h - 5'd12;
        return h;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter for one time field. clr beats inc/en; inc and en together advance once.
// carry only reports wraps caused by en, so user increments never ripple upward.
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6,
    parameter int RST = 0
) (
    input  logic         CLK100MHZ,
    input  logic         res_n,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic [W-1:0] nxt,
    output logic         carry
);

    logic at_max;

    assign at_max = (value == W'(MAX));
    assign carry  = en && at_max && !clr;

    always_comb begin
        nxt = value;
        if (clr) begin
            nxt = '0;
        end else if (en || inc) begin
            nxt = at_max ? '0 : value + W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge res_n) begin
        if (!res_n) begin
            value <= W'(RST);
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/timekeeper_core.sv
// hh:mm:ss time-of-day counter with prescaler, 12/24h registered BCD display and optional alarm.
// Alarm logic is built only when TIMEKEEPER_ALARM_EN is defined; otherwise alarm_out is tied 0.
module timekeeper_core
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int RST_HR        = 0,
    parameter int RST_MIN       = 0
) (
    input  logic       CLK100MHZ,
    input  logic       res_n,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       pause,
    input  logic       clr,
    input  logic       mode12,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output bcd_t       hr_t,
    output bcd_t       hr_o,
    output bcd_t       min_t,
    output bcd_t       min_o,
    output bcd_t       sec_t,
    output bcd_t       sec_o,
    output logic       pm,
    output logic       sec_pulse,
    output logic       alarm_out
);

    localparam int PC_W = $clog2(TICKS_PER_SEC);
    localparam logic [7:0] RST_HR24  = to_bcd2(6'(RST_HR));
    localparam logic [7:0] RST_HR12  = to_bcd2({1'b0, hr_to_12(5'(RST_HR))});
    localparam logic [7:0] RST_MINBC = to_bcd2(6'(RST_MIN));
    localparam logic       RST_PM    = (RST_HR >= 12);

    logic [PC_W-1:0] pc;
    logic            tick;
    logic [5:0]      sec, sec_nxt, min, min_nxt;
    logic [4:0]      hr, hr_nxt;
    logic            sec_carry, min_carry, hr_wrap;
    logic [4:0]      hr_shown;
    logic [7:0]      hr_bcd, min_bcd, sec_bcd;
    logic [7:0]      hr_q, min_q, sec_q;

    assign tick = !pause && !clr && (pc == PC_W'(TICKS_PER_SEC - 1));

    always_ff @(posedge CLK100MHZ or negedge res_n) begin
        if (!res_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (!pause) begin
            pc <= tick ? '0 : pc + PC_W'(1);
        end
    end

    mod_counter #(.MAX(SEC_MAX), .W(6), .RST(0)) u_sec (
        .CLK100MHZ(CLK100MHZ), .res_n(res_n), .en(tick), .inc(1'b0), .clr(clr),
        .value(sec), .nxt(sec_nxt), .carry(sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .W(6), .RST(RST_MIN)) u_min (
        .CLK100MHZ(CLK100MHZ), .res_n(res_n), .en(sec_carry), .inc(inc_min), .clr(clr),
        .value(min), .nxt(min_nxt), .carry(min_carry)
    );

    mod_counter #(.MAX(HR_MAX), .W(5), .RST(RST_HR)) u_hr (
        .CLK100MHZ(CLK100MHZ), .res_n(res_n), .en(min_carry), .inc(inc_hr), .clr(clr),
        .value(hr), .nxt(hr_nxt), .carry(hr_wrap)
    );

    assign hr_shown = mode12 ? hr_to_12(hr) : hr;
    assign hr_bcd   = to_bcd2({1'b0, hr_shown});
    assign min_bcd  = to_bcd2(min);
    assign sec_bcd  = to_bcd2(sec);

    always_ff @(posedge CLK100MHZ or negedge res_n) begin
        if (!res_n) begin
            hr_q      <= RST_HR24;
            min_q     <= RST_MINBC;
            sec_q     <= '0;
            pm        <= RST_PM;
            sec_pulse <= 1'b0;
        end else begin
            hr_q      <= hr_bcd;
            min_q     <= min_bcd;
            sec_q     <= sec_bcd;
            pm        <= (hr >= 5'd12);
            sec_pulse <= tick;
        end
    end

    // The reset value of the hour digits depends on mode12, so it is selected after the register.
    assign hr_t  = (!res_n && mode12) ? RST_HR12[7:4] : hr_q[7:4];
    assign hr_o  = (!res_n && mode12) ? RST_HR12[3:0] : hr_q[3:0];
    assign min_t = min_q[7:4];
    assign min_o = min_q[3:0];
    assign sec_t = sec_q[7:4];
    assign sec_o = sec_q[3:0];

`ifdef TIMEKEEPER_ALARM_EN
    logic alarm_set;
    logic unused_ok;

    // Out-of-range alarm settings can never equal a legal hr/min, so no extra range check is needed.
    assign alarm_set = alarm_arm && !clr && (tick || inc_min || inc_hr) && (sec_nxt == 6'd0)
                       && (hr_nxt == alarm_hr) && (min_nxt == alarm_min);
    assign unused_ok = hr_wrap;

    always_ff @(posedge CLK100MHZ or negedge res_n) begin
        if (!res_n) begin
            alarm_out <= 1'b0;
        end else if (clr || !alarm_arm) begin
            alarm_out <= 1'b0;
        end else if (alarm_set) begin
            alarm_out <= 1'b1;
        end else if (alarm_ack) begin
            alarm_out <= 1'b0;
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{alarm_hr, alarm_min, alarm_arm, alarm_ack, sec_nxt, min_nxt, hr_nxt, hr_wrap};
    assign alarm_out = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench for timekeeper_core with TICKS_PER_SEC=4; alarm checks follow TIMEKEEPER_ALARM_EN.
module tb_timekeeper_core;

    logic       CLK100MHZ;
    logic       res_n;
    logic       inc_min, inc_hr, pause, clr, mode12;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       alarm_arm, alarm_ack;
    logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
    logic       pm, sec_pulse, alarm_out;
    logic [23:0] disp;

`ifdef TIMEKEEPER_ALARM_EN
    localparam logic ALARM_ON = 1'b1;
`else
    localparam logic ALARM_ON = 1'b0;
`endif

    int tests  = 0;
    int failed = 0;

    timekeeper_core #(.TICKS_PER_SEC(4), .RST_HR(0), .RST_MIN(0)) dut (
        .CLK100MHZ(CLK100MHZ), .res_n(res_n), .inc_min(inc_min), .inc_hr(inc_hr),
        .pause(pause), .clr(clr), .mode12(mode12), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .hr_t(hr_t), .hr_o(hr_o),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o), .pm(pm),
        .sec_pulse(sec_pulse), .alarm_out(alarm_out)
    );

    assign disp = {hr_t, hr_o, min_t, min_o, sec_t, sec_o};

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        int          h;
        int          m;
        int          s;
        logic [23:0] d24;
        logic [23:0] d12;
        logic        pm;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic pulse_inc_hr();
        inc_hr = 1'b1;
        step();
        inc_hr = 1'b0;
    endtask

    task automatic pulse_inc_min();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
    endtask

    // Leaves the counter paused at h:m:s with prescaler 0 and the display already updated.
    task automatic set_time(input int h, input int m, input int s);
        pause = 1'b0;
        clr   = 1'b1;
        step();
        clr = 1'b0;
        repeat (s * 4) step();
        pause = 1'b1;
        repeat (h) pulse_inc_hr();
        repeat (m) pulse_inc_min();
        step();
    endtask

    initial begin
        int          pulses;
        logic [23:0] held;
        logic        moved;

        vecs[0] = '{h: 0,  m: 0,  s: 0,  d24: 24'h000000, d12: 24'h120000, pm: 1'b0};
        vecs[1] = '{h: 12, m: 34, s: 56, d24: 24'h123456, d12: 24'h123456, pm: 1'b1};
        vecs[2] = '{h: 13, m: 5,  s: 9,  d24: 24'h130509, d12: 24'h010509, pm: 1'b1};
        vecs[3] = '{h: 23, m: 59, s: 58, d24: 24'h235958, d12: 24'h115958, pm: 1'b1};
        vecs[4] = '{h: 11, m: 59, s: 1,  d24: 24'h115901, d12: 24'h115901, pm: 1'b0};
        vecs[5] = '{h: 9,  m: 7,  s: 30, d24: 24'h090730, d12: 24'h090730, pm: 1'b0};
        vecs[6] = '{h: 1,  m: 0,  s: 10, d24: 24'h010010, d12: 24'h010010, pm: 1'b0};
        vecs[7] = '{h: 20, m: 45, s: 2,  d24: 24'h204502, d12: 24'h084502, pm: 1'b1};

        res_n = 1'b0;
        inc_min = 1'b0; inc_hr = 1'b0; pause = 1'b0; clr = 1'b0; mode12 = 1'b0;
        alarm_hr = 5'd7; alarm_min = 6'd30; alarm_arm = 1'b0; alarm_ack = 1'b0;

        // Reset state, including the 12-hour view of hour 0.
        #2;
        check("reset_disp24", 32'(disp), 32'h000000);
        check("reset_pm", 32'(pm), 32'd0);
        check("reset_sec_pulse", 32'(sec_pulse), 32'd0);
        check("reset_alarm", 32'(alarm_out), 32'd0);
        mode12 = 1'b1;
        #1;
        check("reset_disp12", 32'(disp), 32'h120000);
        mode12 = 1'b0;
        @(negedge CLK100MHZ);
        res_n = 1'b1;
        step();
        check("post_reset_disp", 32'(disp), 32'h000000);

        // Table: each time in 24h, then 12h, then 24h again (mode12 must not disturb the counts).
        for (int i = 0; i < 8; i++) begin
            set_time(vecs[i].h, vecs[i].m, vecs[i].s);
            mode12 = 1'b0;
            step();
            check($sformatf("vec%0d_d24", i), 32'(disp), 32'(vecs[i].d24));
            check($sformatf("vec%0d_pm24", i), 32'(pm), 32'(vecs[i].pm));
            mode12 = 1'b1;
            step();
            check($sformatf("vec%0d_d12", i), 32'(disp), 32'(vecs[i].d12));
            check($sformatf("vec%0d_pm12", i), 32'(pm), 32'(vecs[i].pm));
            mode12 = 1'b0;
            step();
            check($sformatf("vec%0d_back24", i), 32'(disp), 32'(vecs[i].d24));
        end

        // Free run across midnight.
        set_time(23, 59, 58);
        check("midnight_pre", 32'(disp), 32'h235958);
        check("midnight_pm_pre", 32'(pm), 32'd1);
        pause  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (sec_pulse === 1'b1) pulses++;
        end
        step();
        check("midnight_disp", 32'(disp), 32'h000000);
        check("midnight_pm_post", 32'(pm), 32'd0);
        check("midnight_pulses", 32'(pulses), 32'd2);

        // inc_min coinciding with the tick that carries the minute.
        set_time(10, 59, 59);
        pause = 1'b0;
        repeat (3) step();
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        pause   = 1'b1;
        step();
        check("inc_on_tick", 32'(disp), 32'h110000);

        // inc_min alone wraps the minute without touching the hour.
        set_time(10, 59, 30);
        pulse_inc_min();
        step();
        check("inc_min_wrap", 32'(disp), 32'h100030);

        // Pause holds seconds; inc_hr and clr still act.
        set_time(23, 10, 20);
        held  = disp;
        moved = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sec_pulse === 1'b1) pulses++;
            if (disp !== held) moved = 1'b1;
        end
        check("pause_disp", 32'(held), 32'h231020);
        check("pause_frozen", 32'(moved), 32'd0);
        check("pause_pulses", 32'(pulses), 32'd0);
        pulse_inc_hr();
        step();
        check("pause_inc_hr", 32'(disp), 32'h001020);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        check("pause_clr", 32'(disp), 32'h000000);

        // Asynchronous reset in the middle of counting.
        set_time(5, 6, 7);
        pause = 1'b0;
        repeat (6) step();
        res_n = 1'b0;
        #1;
        check("midrst_disp", 32'(disp), 32'h000000);
        check("midrst_pulse", 32'(sec_pulse), 32'd0);
        @(negedge CLK100MHZ);
        res_n = 1'b1;
        step();

        // Alarm 07:30 reached by free run, held until acknowledged.
        alarm_hr  = 5'd7;
        alarm_min = 6'd30;
        alarm_arm = 1'b1;
        set_time(7, 29, 58);
        pause = 1'b0;
        repeat (7) step();
        check("alarm_before", 32'(alarm_out), 32'd0);
        step();
        check("alarm_fire", 32'(alarm_out), 32'(ALARM_ON));
        repeat (10) step();
        check("alarm_hold", 32'(alarm_out), 32'(ALARM_ON));
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check("alarm_ack", 32'(alarm_out), 32'd0);

        // Out-of-range alarm minute never fires.
        alarm_min = 6'd60;
        set_time(7, 59, 58);
        pause = 1'b0;
        moved = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (alarm_out !== 1'b0) moved = 1'b1;
        end
        check("alarm_min60", 32'(moved), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
